bus_hub_n: RTL

Parametrised N-port bus hub between the CPU host port and N memory-mapped devices, generalising the fixed-count hubs. Address, write data and write mask are broadcast to every device. Each device decodes its own address and reports it on `device_active`. The hub forwards strobes to the single selected device, registers its response, and adds what the fixed hubs lack:

- deterministic lowest-index priority when several devices claim an address;
- an error response for unmapped addresses;
- an optional ready-timeout.

---
 rtl/bus_hub_n.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/bus_hub_n.sv
// rtl/bus_hub_n.sv - N-port host-to-device bus hub with priority select, unmapped error and optional ready-timeout
// Optional feature macro: BUS_HUB_TIMEOUT_EN (enables the BUSY-state ready-timeout).
module bus_hub_n #(
    parameter int          N_DEVICES      = 5,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [31:0]               host_address,
    input  logic [31:0]               host_data_write,
    input  logic [3:0]                host_write_mask,
    input  logic                      host_wen,
    input  logic                      host_ren,
    output logic [31:0]               host_data_read,
    output logic                      host_ready,
    output logic [32*N_DEVICES-1:0]   device_address,
    output logic [32*N_DEVICES-1:0]   device_data_write,
    output logic [4*N_DEVICES-1:0]    device_write_mask,
    output logic [N_DEVICES-1:0]      device_wen,
    output logic [N_DEVICES-1:0]      device_ren,
    input  logic [N_DEVICES-1:0]      device_ready,
    input  logic [32*N_DEVICES-1:0]   device_data_read,
    input  logic [N_DEVICES-1:0]      device_active,
    output logic                      bus_error,
    output logic [1:0]                bus_err_code
);
    localparam int SEL_W = (N_DEVICES > 1) ? $clog2(N_DEVICES) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t           state, state_n;
    logic [SEL_W-1:0] sel, first_idx;
    logic             is_write, err_flag;
    logic             request, any_active, sel_ready, tmo_hit;
    logic [31:0]      sel_rdata;

    assign request    = host_wen | host_ren;
    assign any_active = |device_active;

    assign device_address    = {N_DEVICES{host_address}};
    assign device_data_write = {N_DEVICES{host_data_write}};
    assign device_write_mask = {N_DEVICES{host_write_mask}};

    // Descending scan so the lowest active index is the one that sticks.
    always_comb begin
        first_idx = '0;
        for (int i = N_DEVICES - 1; i >= 0; i--) begin
            if (device_active[i]) first_idx = SEL_W'(i);
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < N_DEVICES; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_ready = device_ready[i];
                sel_rdata = device_data_read[i*32 +: 32];
            end
        end
    end

`ifdef BUS_HUB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt;

    // Counter holds the number of BUSY cycles already completed.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            tmo_cnt <= '0;
        else if (state == BUSY)  tmo_cnt <= tmo_cnt + 1'b1;
        else                     tmo_cnt <= '0;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (request) state_n = any_active ? BUSY : RESP;
            BUSY: if (sel_ready || tmo_hit) state_n = RESP;
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        device_wen = '0;
        device_ren = '0;
        if (state == BUSY) begin
            for (int i = 0; i < N_DEVICES; i++) begin
                if (sel == SEL_W'(i)) begin
                    device_wen[i] = is_write;
                    device_ren[i] = !is_write;
                end
            end
        end
    end

    assign host_ready = (state == RESP);
    assign bus_error  = (state == RESP) && err_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel            <= '0;
            is_write       <= 1'b0;
            err_flag       <= 1'b0;
            host_data_read <= '0;
            bus_err_code   <= 2'd0;
        end else begin
            case (state)
                IDLE: if (request) begin
                    sel      <= first_idx;
                    is_write <= host_wen;
                    err_flag <= !any_active;
                    if (!any_active) begin
                        host_data_read <= ERR_RDATA;
                        bus_err_code   <= 2'd1;
                    end
                end
                BUSY: begin
                    // Ready in the final allowed cycle takes precedence over the timeout.
                    if (sel_ready) begin
                        host_data_read <= sel_rdata;
                    end else if (tmo_hit) begin
                        host_data_read <= ERR_RDATA;
                        bus_err_code   <= 2'd2;
                        err_flag       <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
